// File: rtl/sent_rx_out_arbiter.sv
// rtl/sent_rx_out_arbiter.sv - round-robin arbiter sharing the RX FIFO write port between fast and slow SENT requesters
module sent_rx_out_arbiter #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk_rx,
  input  logic             reset_rx,
  input  logic             fast_req,
  input  logic             fast_ch,
  input  logic [11:0]      fast_data,
  output logic             fast_ack,
  input  logic             slow_req,
  input  logic [7:0]       slow_id,
  input  logic [15:0]      slow_data,
  output logic             slow_ack,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [17:0]      fifo_wr_data,
  output logic             drop_fast,
  output logic             drop_slow,
  output logic [CNT_W-1:0] drop_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic GRANT_FAST = 1'b0;
  localparam logic GRANT_SLOW = 1'b1;

  typedef enum logic {ST_IDLE, ST_SLOW_DATA} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [WAIT_W-1:0]  fast_wait_q, fast_wait_d;
  logic [WAIT_W-1:0]  slow_wait_q, slow_wait_d;
  logic               fifo_wr_en_q, fifo_wr_en_d;
  logic [17:0]        fifo_wr_data_q, fifo_wr_data_d;
  logic               fast_ack_q, fast_ack_d;
  logic               slow_ack_q, slow_ack_d;
  logic               drop_fast_q, drop_fast_d;
  logic               drop_slow_q, drop_slow_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;

  logic               fast_elig, slow_elig;
  logic               grant_fast, grant_slow;
  logic [CNT_W:0]     cnt_sum;

  // Arbitration, watchdog and next-state/output computation; a request whose
  // own ack is currently high is stale and ignored for this cycle.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    fast_wait_d    = fast_wait_q;
    slow_wait_d    = slow_wait_q;
    fifo_wr_en_d   = 1'b0;
    fifo_wr_data_d = '0;
    fast_ack_d     = 1'b0;
    slow_ack_d     = 1'b0;
    drop_fast_d    = 1'b0;
    drop_slow_d    = 1'b0;
    grant_fast     = 1'b0;
    grant_slow     = 1'b0;
    fast_elig      = fast_req & ~fast_ack_q;
    slow_elig      = slow_req & ~slow_ack_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_full) begin
          if (fast_elig && (!slow_elig || last_grant_q == GRANT_SLOW)) begin
            grant_fast = 1'b1;
          end else if (slow_elig) begin
            grant_slow = 1'b1;
          end
        end

        if (grant_fast) begin
          fifo_wr_en_d   = 1'b1;
          fifo_wr_data_d = {1'b0, fast_ch, 4'h0, fast_data};
          fast_ack_d     = 1'b1;
          last_grant_d   = GRANT_FAST;
          fast_wait_d    = '0;
        end else if (fast_elig) begin
          if (fast_wait_q == WAIT_LAST) begin
            fast_ack_d  = 1'b1;
            drop_fast_d = 1'b1;
            fast_wait_d = '0;
          end else begin
            fast_wait_d = fast_wait_q + WAIT_W'(1);
          end
        end else begin
          fast_wait_d = '0;
        end

        if (grant_slow) begin
          fifo_wr_en_d   = 1'b1;
          fifo_wr_data_d = {2'b10, 8'h00, slow_id};
          last_grant_d   = GRANT_SLOW;
          slow_wait_d    = '0;
          state_d        = ST_SLOW_DATA;
        end else if (slow_elig) begin
          if (slow_wait_q == WAIT_LAST) begin
            slow_ack_d  = 1'b1;
            drop_slow_d = 1'b1;
            slow_wait_d = '0;
          end else begin
            slow_wait_d = slow_wait_q + WAIT_W'(1);
          end
        end else begin
          slow_wait_d = '0;
        end
      end

      ST_SLOW_DATA: begin
        // Message stays atomic: no watchdog, the fast requester simply waits.
        if (!fifo_full) begin
          fifo_wr_en_d   = 1'b1;
          fifo_wr_data_d = {2'b11, slow_data};
          slow_ack_d     = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    cnt_sum = {1'b0, drop_count_q} + {{CNT_W{1'b0}}, drop_fast_d}
            + {{CNT_W{1'b0}}, drop_slow_d};
    drop_count_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // State and registered outputs; reset leaves fast winning the first tie.
  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GRANT_SLOW;
      fast_wait_q    <= '0;
      slow_wait_q    <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      fast_ack_q     <= 1'b0;
      slow_ack_q     <= 1'b0;
      drop_fast_q    <= 1'b0;
      drop_slow_q    <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      fast_wait_q    <= fast_wait_d;
      slow_wait_q    <= slow_wait_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      fast_ack_q     <= fast_ack_d;
      slow_ack_q     <= slow_ack_d;
      drop_fast_q    <= drop_fast_d;
      drop_slow_q    <= drop_slow_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign fast_ack     = fast_ack_q;
  assign slow_ack     = slow_ack_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign drop_fast    = drop_fast_q;
  assign drop_slow    = drop_slow_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_sent_rx_out_arbiter.sv
// tb/tb_sent_rx_out_arbiter.sv - directed scoreboard bench for sent_rx_out_arbiter
module tb_sent_rx_out_arbiter;

  logic        clk_rx = 1'b0;
  logic        reset_rx = 1'b1;
  logic        fast_req = 1'b0;
  logic        fast_ch = 1'b0;
  logic [11:0] fast_data = '0;
  logic        fast_ack;
  logic        slow_req = 1'b0;
  logic [7:0]  slow_id = '0;
  logic [15:0] slow_data = '0;
  logic        slow_ack;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [17:0] fifo_wr_data;
  logic        drop_fast;
  logic        drop_slow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_w;
  int hit_cycle;

  sent_rx_out_arbiter #(.MAX_WAIT(64), .CNT_W(8)) dut (
    .clk_rx       (clk_rx),
    .reset_rx     (reset_rx),
    .fast_req     (fast_req),
    .fast_ch      (fast_ch),
    .fast_data    (fast_data),
    .fast_ack     (fast_ack),
    .slow_req     (slow_req),
    .slow_id      (slow_id),
    .slow_data    (slow_data),
    .slow_ack     (slow_ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .drop_fast    (drop_fast),
    .drop_slow    (drop_slow),
    .drop_count   (drop_count)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_rx);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    chk({tag, "_fast_ack"}, 32'(fast_ack), 32'd0);
    chk({tag, "_slow_ack"}, 32'(slow_ack), 32'd0);
    chk({tag, "_drop_fast"}, 32'(drop_fast), 32'd0);
    chk({tag, "_drop_slow"}, 32'(drop_slow), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
  endtask

  // Scoreboard: every FIFO write must match the oldest expected word.
  always @(negedge clk_rx) begin
    if (!reset_rx && fifo_wr_en) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_write observed=%h expected=none", fifo_wr_data);
      end
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk("wr_data", 32'(fifo_wr_data), 32'(exp_w));
      end
    end
  end

  initial begin
    bit fast_pat[6];
    bit slow_pat[6];
    fast_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    slow_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) cyc();
    chk_idle_outputs("reset");
    reset_rx = 1'b0;
    cyc();

    // 1: single fast word on channel 2
    fast_req = 1'b1; fast_ch = 1'b1; fast_data = 12'hABC;
    exp_q.push_back(18'h10ABC);
    cyc();
    chk("t1_fast_ack", 32'(fast_ack), 32'd1);
    chk("t1_drop_fast", 32'(drop_fast), 32'd0);
    chk("t1_wr_en", 32'(fifo_wr_en), 32'd1);
    fast_req = 1'b0;
    cyc();
    chk("t1_ack_pulse", 32'(fast_ack), 32'd0);
    chk("t1_wr_pulse", 32'(fifo_wr_en), 32'd0);

    // 2: slow message, ID then data on consecutive cycles
    slow_req = 1'b1; slow_id = 8'h29; slow_data = 16'h1234;
    exp_q.push_back(18'h20029);
    exp_q.push_back(18'h31234);
    cyc();
    chk("t2_id_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t2_id_no_ack", 32'(slow_ack), 32'd0);
    cyc();
    chk("t2_data_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t2_slow_ack", 32'(slow_ack), 32'd1);
    slow_req = 1'b0;
    cyc();
    chk("t2_idle", 32'(fifo_wr_en), 32'd0);

    // 3: both held continuously, round-robin with atomic slow messages
    fast_req = 1'b1; fast_ch = 1'b0; fast_data = 12'h5A5;
    slow_req = 1'b1; slow_id = 8'h2A; slow_data = 16'hBEEF;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(18'h005A5);
      exp_q.push_back(18'h2002A);
      exp_q.push_back(18'h3BEEF);
    end
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("t3_fast_ack_%0d", i), 32'(fast_ack), 32'(fast_pat[i]));
      chk($sformatf("t3_slow_ack_%0d", i), 32'(slow_ack), 32'(slow_pat[i]));
    end
    fast_req = 1'b0; slow_req = 1'b0;
    cyc();

    // 4: full while in the data phase holds the message; fast follows afterwards
    slow_req = 1'b1; slow_id = 8'h11; slow_data = 16'h00FF;
    exp_q.push_back(18'h20011);
    cyc();
    chk("t4_id_wr_en", 32'(fifo_wr_en), 32'd1);
    fast_req = 1'b1; fast_ch = 1'b1; fast_data = 12'h321;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t4_hold_wr_%0d", i), 32'(fifo_wr_en), 32'd0);
    end
    fifo_full = 1'b0;
    exp_q.push_back(18'h300FF);
    exp_q.push_back(18'h10321);
    cyc();
    chk("t4_data_slow_ack", 32'(slow_ack), 32'd1);
    chk("t4_data_no_fast", 32'(fast_ack), 32'd0);
    slow_req = 1'b0;
    cyc();
    chk("t4_fast_ack", 32'(fast_ack), 32'd1);
    fast_req = 1'b0;
    cyc();

    // 5: fast watchdog under constant full
    fifo_full = 1'b1;
    fast_req = 1'b1; fast_ch = 1'b0; fast_data = 12'h777;
    hit_cycle = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (fast_ack) begin
        hit_cycle = i;
        break;
      end
    end
    chk("t5_drop_cycle", 32'(hit_cycle), 32'd64);
    chk("t5_drop_fast", 32'(drop_fast), 32'd1);
    chk("t5_drop_slow", 32'(drop_slow), 32'd0);
    chk("t5_drop_count", 32'(drop_count), 32'd1);
    fast_req = 1'b0;
    cyc();
    chk("t5_drop_pulse", 32'(drop_fast), 32'd0);

    // 5b: both time out together
    fast_req = 1'b1; slow_req = 1'b1; slow_id = 8'h44; slow_data = 16'hCAFE;
    hit_cycle = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (fast_ack || slow_ack) begin
        hit_cycle = i;
        break;
      end
    end
    chk("t5b_drop_cycle", 32'(hit_cycle), 32'd64);
    chk("t5b_fast_ack", 32'(fast_ack), 32'd1);
    chk("t5b_slow_ack", 32'(slow_ack), 32'd1);
    chk("t5b_drop_fast", 32'(drop_fast), 32'd1);
    chk("t5b_drop_slow", 32'(drop_slow), 32'd1);
    chk("t5b_drop_count", 32'(drop_count), 32'd3);
    fast_req = 1'b0; slow_req = 1'b0; fifo_full = 1'b0;
    cyc();

    // Drops left last_grant at FAST, so a tie now goes to slow first
    fast_req = 1'b1; fast_ch = 1'b1; fast_data = 12'h0F0;
    slow_req = 1'b1; slow_id = 8'h55; slow_data = 16'hA5A5;
    exp_q.push_back(18'h20055);
    exp_q.push_back(18'h3A5A5);
    exp_q.push_back(18'h100F0);
    cyc();
    chk("t5c_no_fast_ack", 32'(fast_ack), 32'd0);
    cyc();
    chk("t5c_slow_ack", 32'(slow_ack), 32'd1);
    slow_req = 1'b0;
    cyc();
    chk("t5c_fast_ack", 32'(fast_ack), 32'd1);
    fast_req = 1'b0;
    cyc();

    // 6: reset in SLOW_DATA clears outputs at once; fast then served normally
    slow_req = 1'b1; slow_id = 8'h66; slow_data = 16'h6666;
    exp_q.push_back(18'h20066);
    cyc();
    chk("t6_id_wr_en", 32'(fifo_wr_en), 32'd1);
    #2 reset_rx = 1'b1;
    #1 chk_idle_outputs("t6_reset");
    slow_req = 1'b0;
    cyc();
    reset_rx = 1'b0;
    fast_req = 1'b1; fast_ch = 1'b0; fast_data = 12'h9D3;
    exp_q.push_back(18'h009D3);
    cyc();
    chk("t6_fast_ack", 32'(fast_ack), 32'd1);
    chk("t6_wr_en", 32'(fifo_wr_en), 32'd1);
    fast_req = 1'b0;
    repeat (2) cyc();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
